// File: rtl/vsm_pkg.sv
// Shared definitions for the ALU sequencer: widths, FIFO depth, op encoding,
// FSM state encoding and the queued command payload.
package vsm_pkg;

    localparam int unsigned DATA_W     = 4;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned CNT_W      = 2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Queued command, 9 bits: {op, a, b}
    typedef struct packed {
        logic              op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

endpackage

// File: rtl/vsm_cmd_fifo.sv
// Two-entry command FIFO for the ALU sequencer.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   push, din    write one command (caller guarantees not full)
//   pop          discard the head entry (caller guarantees not empty)
//   head         current oldest entry
//   count        number of stored entries (0..2)
module vsm_cmd_fifo
    import vsm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  cmd_t             din,
    output cmd_t             head,
    output logic [CNT_W-1:0] count
);

    cmd_t mem [FIFO_DEPTH];
    logic wr_ptr;
    logic rd_ptr;

    // Storage, pointers and occupancy; simultaneous push/pop keeps count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/vsm_alu_sequencer.sv
// Sequencer that queues ADD/SUB commands and drives an external ALU through
// IDLE -> LOAD -> EXEC -> HOLD, returning results over a valid/ready port.
// Optional feature macro: VSM_ALU_ZERO_FLAG_EN adds the ResZero output.
// Ports:
//   Clk, Rst_n                 clock, asynchronous active-low reset
//   CmdValid/CmdReady          command handshake; CmdOp (0=ADD,1=SUB), CmdA, CmdB
//   A, B, AddSub, EnableAlu    registered drive to the arithmetic unit
//   IB_Alu, Carry              arithmetic unit result and carry-out
//   ResValid/ResReady          result handshake; ResData, ResCarry, ResZero
module vsm_alu_sequencer
    import vsm_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              CmdValid,
    output logic              CmdReady,
    input  logic              CmdOp,
    input  logic [DATA_W-1:0] CmdA,
    input  logic [DATA_W-1:0] CmdB,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              AddSub,
    output logic              EnableAlu,
    input  logic [DATA_W-1:0] IB_Alu,
    input  logic              Carry,
    output logic              ResValid,
    input  logic              ResReady,
    output logic [DATA_W-1:0] ResData,
    output logic              ResCarry
`ifdef VSM_ALU_ZERO_FLAG_EN
    ,
    output logic              ResZero
`endif
);

    state_t           state;
    cmd_t             cmd_in_c;
    cmd_t             head;
    logic [CNT_W-1:0] fifo_count;
    logic             push_c;
    logic             pop_c;
    logic             res_done_c;
    logic             fifo_empty_c;

    // Ready decodes only the registered occupancy, so ResReady never reaches it
    assign CmdReady     = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign fifo_empty_c = (fifo_count == '0);
    assign push_c       = CmdValid & CmdReady;
    assign res_done_c   = ResValid & ResReady;
    assign cmd_in_c     = '{op: CmdOp, a: CmdA, b: CmdB};

    // Head is consumed on entry to LOAD, from IDLE or straight out of HOLD
    assign pop_c = !fifo_empty_c &&
                   ((state == ST_IDLE) || ((state == ST_HOLD) && res_done_c));

    vsm_cmd_fifo u_fifo (
        .clk   (Clk),
        .rst_n (Rst_n),
        .push  (push_c),
        .pop   (pop_c),
        .din   (cmd_in_c),
        .head  (head),
        .count (fifo_count)
    );

    // Sequencer FSM with registered ALU drive and result outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= ST_IDLE;
            A         <= '0;
            B         <= '0;
            AddSub    <= OP_ADD;
            EnableAlu <= 1'b0;
            ResValid  <= 1'b0;
            ResData   <= '0;
            ResCarry  <= 1'b0;
`ifdef VSM_ALU_ZERO_FLAG_EN
            ResZero   <= 1'b0;
`endif
        end else begin
            // Operands change only when a command enters LOAD; the LOAD
            // cycle itself is the settle cycle with EnableAlu still low
            if (pop_c) begin
                A      <= head.a;
                B      <= head.b;
                AddSub <= (head.op == OP_SUB);
            end

            case (state)
                ST_IDLE: begin
                    if (pop_c) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    EnableAlu <= 1'b1;
                    state     <= ST_EXEC;
                end
                ST_EXEC: begin
                    EnableAlu <= 1'b0;
                    ResData   <= IB_Alu;
                    ResCarry  <= Carry;
`ifdef VSM_ALU_ZERO_FLAG_EN
                    ResZero   <= (IB_Alu == '0);
`endif
                    ResValid  <= 1'b1;
                    state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (res_done_c) begin
                        ResValid <= 1'b0;
                        state    <= pop_c ? ST_LOAD : ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vsm_alu_sequencer.sv
// Scoreboard bench for vsm_alu_sequencer with a combinational ALU model that
// tri-states its result while EnableAlu is low.
// Honours VSM_ALU_ZERO_FLAG_EN for the ResZero port.
module tb_vsm_alu_sequencer;
    import vsm_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [3:0] a_bus;
    logic [3:0] b_bus;
    logic       add_sub;
    logic       enable_alu;
    wire  [3:0] ib_alu;
    wire        carry;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_carry;
`ifdef VSM_ALU_ZERO_FLAG_EN
    logic       res_zero;
`endif

    typedef struct {
        logic [3:0] data;
        logic       carry;
        logic       zero;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned hs_q[$];
    int          checks;
    int          failures;
    int unsigned cycle;
    logic [4:0]  alu_res;

    vsm_alu_sequencer dut (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .CmdValid  (cmd_valid),
        .CmdReady  (cmd_ready),
        .CmdOp     (cmd_op),
        .CmdA      (cmd_a),
        .CmdB      (cmd_b),
        .A         (a_bus),
        .B         (b_bus),
        .AddSub    (add_sub),
        .EnableAlu (enable_alu),
        .IB_Alu    (ib_alu),
        .Carry     (carry),
        .ResValid  (res_valid),
        .ResReady  (res_ready),
        .ResData   (res_data),
        .ResCarry  (res_carry)
`ifdef VSM_ALU_ZERO_FLAG_EN
        ,
        .ResZero   (res_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Arithmetic unit: SUB computes B + ~A + 1 so carry means "no borrow"
    always_comb begin
        if (add_sub) alu_res = {1'b0, b_bus} + {1'b0, ~a_bus} + 5'd1;
        else         alu_res = {1'b0, b_bus} + {1'b0, a_bus};
    end
    assign ib_alu = enable_alu ? alu_res[3:0] : 4'bz;
    assign carry  = enable_alu ? alu_res[4]   : 1'bz;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every result handshake is checked against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=%0h required=none", res_data);
            end else begin
                e = exp_q.pop_front();
                chk("res_data", 8'(res_data), 8'(e.data));
                chk("res_carry", 8'(res_carry), 8'(e.carry));
`ifdef VSM_ALU_ZERO_FLAG_EN
                chk("res_zero", 8'(res_zero), 8'(e.zero));
`endif
            end
            hs_q.push_back(cycle);
        end
    end

    // Offer a command (call just after a rising edge); expectation queued on acceptance
    task automatic send(input logic op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] ed, input logic ec, input logic ez);
        exp_t e;
        bit   ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL cmd_accept_timeout actual=not_accepted required=accepted");
            cmd_valid = 1'b0;
            return;
        end
        e.data  = ed;
        e.carry = ec;
        e.zero  = ez;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned c0;
        bit          seen;
        checks    = 0;
        failures  = 0;
        cycle     = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_ADD;
        cmd_a     = 4'h0;
        cmd_b     = 4'h0;
        res_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 8'(cmd_ready), 8'd1);
        chk("rst_res_valid", 8'(res_valid), 8'd0);
        chk("rst_enable_alu", 8'(enable_alu), 8'd0);
        chk("rst_add_sub", 8'(add_sub), 8'd0);
        chk("rst_a", 8'(a_bus), 8'd0);
        chk("rst_b", 8'(b_bus), 8'd0);
        chk("rst_res_data", 8'(res_data), 8'd0);
        chk("rst_res_carry", 8'(res_carry), 8'd0);
`ifdef VSM_ALU_ZERO_FLAG_EN
        chk("rst_res_zero", 8'(res_zero), 8'd0);
`endif

        // Latency: ADD 3+5, accepted on the first edge after reset release
        rst_n = 1'b1;
        c0    = cycle;
        send(OP_ADD, 4'd3, 4'd5, 4'h8, 1'b0, 1'b0);
        chk("first_accept_edge", 8'(cycle - c0), 8'd1);
        @(posedge clk); #1;
        chk("load_enable_alu", 8'(enable_alu), 8'd0);
        chk("load_a", 8'(a_bus), 8'd3);
        chk("load_b", 8'(b_bus), 8'd5);
        chk("load_add_sub", 8'(add_sub), 8'd0);
        chk("load_res_valid", 8'(res_valid), 8'd0);
        @(posedge clk); #1;
        chk("exec_enable_alu", 8'(enable_alu), 8'd1);
        chk("exec_res_valid", 8'(res_valid), 8'd0);
        @(posedge clk); #1;
        chk("hold_res_valid", 8'(res_valid), 8'd1);
        chk("hold_enable_alu", 8'(enable_alu), 8'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("hold_stable_valid", 8'(res_valid), 8'd1);
        chk("hold_stable_data", 8'(res_data), 8'h8);
        res_ready = 1'b1;
        wait_drain();

        // Streaming with ResReady high: one result every 3 cycles
        hs_q.delete();
        send(OP_ADD, 4'd9, 4'd8, 4'h1, 1'b1, 1'b0);
        send(OP_ADD, 4'd8, 4'd8, 4'h0, 1'b1, 1'b1);
        send(OP_SUB, 4'd3, 4'd5, 4'h2, 1'b1, 1'b0);
        send(OP_SUB, 4'd5, 4'd3, 4'hE, 1'b0, 1'b0);
        wait_drain();
        chk("stream_results", 8'(hs_q.size()), 8'd4);
        if (hs_q.size() == 4) begin
            for (int i = 0; i < 3; i++) begin
                chk("stream_interval", 8'(hs_q[i+1] - hs_q[i]), 8'd3);
            end
        end

        // Backpressure: one held in HOLD, two queued, fourth refused until a pulse
        res_ready = 1'b0;
        send(OP_ADD, 4'd1, 4'd2, 4'h3, 1'b0, 1'b0);
        send(OP_SUB, 4'd4, 4'd4, 4'h0, 1'b1, 1'b1);
        send(OP_ADD, 4'd15, 4'd15, 4'hE, 1'b1, 1'b0);
        fork
            send(OP_SUB, 4'd7, 4'd2, 4'hB, 1'b0, 1'b0);
            begin
                repeat (4) @(posedge clk);
                #1;
                chk("bp_cmd_ready", 8'(cmd_ready), 8'd0);
                chk("bp_res_valid", 8'(res_valid), 8'd1);
                chk("bp_res_data", 8'(res_data), 8'h3);
                res_ready = 1'b1;
                @(posedge clk);
                #1;
                res_ready = 1'b0;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        chk("bp_second_held", 8'(res_data), 8'h0);
        res_ready = 1'b1;
        wait_drain();

        // Reset during EXEC of a queued pair
        send(OP_ADD, 4'd6, 4'd7, 4'hD, 1'b0, 1'b0);
        send(OP_SUB, 4'd1, 4'd9, 4'h8, 1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (enable_alu) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("reach_exec", 8'(seen), 8'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_enable_alu", 8'(enable_alu), 8'd0);
        chk("arst_res_valid", 8'(res_valid), 8'd0);
        chk("arst_cmd_ready", 8'(cmd_ready), 8'd1);
        chk("arst_a", 8'(a_bus), 8'd0);
        chk("arst_b", 8'(b_bus), 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        chk("no_result_after_reset", 8'(seen), 8'd0);
        @(posedge clk);
        #1;
        send(OP_ADD, 4'd2, 4'd4, 4'h6, 1'b0, 1'b0);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
